// File: rtl/mips_pkg.sv
// Shared MIPS-subset definitions: widths, opcode/funct values, ALU codes and
// the control bundle produced by the decoder.
package mips_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_CNT_W      = 16;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       aluSrcImm;
    logic       branch;
    logic [3:0] aluOp;
  } ctrl_t;

endpackage

// File: rtl/id_operand_stage_if.sv
// Bus between the decode/operand stage and its neighbours: IF/ID inputs,
// register file read ports, forwarding sources and the ID/EX register outputs.
interface id_operand_stage_if
  import mips_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W
);
  logic [DATA_W-1:0]     ifidInstr;
  logic                  ifidValid;
  logic [DATA_W-1:0]     ifidPC;
  logic                  flush;
  logic [REG_ADDR_W-1:0] R1point;
  logic [REG_ADDR_W-1:0] R2point;
  logic [DATA_W-1:0]     R1;
  logic [DATA_W-1:0]     R2;
  logic [DATA_W-1:0]     exFwdData;
  logic                  memRegWrite;
  logic [REG_ADDR_W-1:0] memDest;
  logic [DATA_W-1:0]     memFwdData;
  logic                  wbRegWrite;
  logic [REG_ADDR_W-1:0] wbDest;
  logic [DATA_W-1:0]     wbFwdData;
  logic                  stallIF;
  logic                  idexValid;
  logic [DATA_W-1:0]     idexPC;
  logic [DATA_W-1:0]     idexOpA;
  logic [DATA_W-1:0]     idexOpB;
  logic [DATA_W-1:0]     idexImm;
  logic [REG_ADDR_W-1:0] idexDest;
  logic                  idexRegWrite;
  logic                  idexMemRead;
  logic                  idexMemWrite;
  logic                  idexAluSrcImm;
  logic [3:0]            idexAluOp;
  logic                  idexBranch;
  logic [CNT_W-1:0]      stallCount;
  logic [CNT_W-1:0]      flushCount;

  // Surrounding pipeline / environment side
  modport master (
    output ifidInstr, ifidValid, ifidPC, flush, R1, R2, exFwdData,
           memRegWrite, memDest, memFwdData, wbRegWrite, wbDest, wbFwdData,
    input  R1point, R2point, stallIF, idexValid, idexPC, idexOpA, idexOpB,
           idexImm, idexDest, idexRegWrite, idexMemRead, idexMemWrite,
           idexAluSrcImm, idexAluOp, idexBranch, stallCount, flushCount
  );

  // Decode/operand stage side
  modport slave (
    input  ifidInstr, ifidValid, ifidPC, flush, R1, R2, exFwdData,
           memRegWrite, memDest, memFwdData, wbRegWrite, wbDest, wbFwdData,
    output R1point, R2point, stallIF, idexValid, idexPC, idexOpA, idexOpB,
           idexImm, idexDest, idexRegWrite, idexMemRead, idexMemWrite,
           idexAluSrcImm, idexAluOp, idexBranch, stallCount, flushCount
  );

endinterface

// File: rtl/id_operand_stage_decoder.sv
// Pure combinational instruction decoder: controls, destination register,
// sign-extended immediate and whether the op reads rt.
module id_decoder
  import mips_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [DATA_W-1:0]     instr,
  output ctrl_t                 ctrl,
  output logic [REG_ADDR_W-1:0] dest,
  output logic [DATA_W-1:0]     imm,
  output logic                  uses_rt
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_shamt;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_shamt = ^instr[10:6];
  assign imm          = {{(DATA_W-16){instr[15]}}, instr[15:0]};

  // Map opcode/funct to controls; anything unrecognised stays an all-zero NOP
  always_comb begin
    ctrl    = '0;
    dest    = '0;
    uses_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
          ctrl.regWrite = 1'b1;
          dest          = REG_ADDR_W'(instr[15:11]);
          case (funct)
            FN_SUB:  ctrl.aluOp = ALU_SUB;
            FN_AND:  ctrl.aluOp = ALU_AND;
            FN_OR:   ctrl.aluOp = ALU_OR;
            FN_SLT:  ctrl.aluOp = ALU_SLT;
            default: ctrl.aluOp = ALU_ADD;
          endcase
        end
      end
      OP_ADDI: begin
        ctrl.regWrite  = 1'b1;
        ctrl.aluSrcImm = 1'b1;
        ctrl.aluOp     = ALU_ADD;
        dest           = REG_ADDR_W'(instr[20:16]);
      end
      OP_LW: begin
        ctrl.regWrite  = 1'b1;
        ctrl.memRead   = 1'b1;
        ctrl.aluSrcImm = 1'b1;
        ctrl.aluOp     = ALU_ADD;
        dest           = REG_ADDR_W'(instr[20:16]);
      end
      OP_SW: begin
        ctrl.memWrite  = 1'b1;
        ctrl.aluSrcImm = 1'b1;
        ctrl.aluOp     = ALU_ADD;
        uses_rt        = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.aluOp  = ALU_SUB;
        uses_rt     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand stage: register file addressing, EX/MEM/WB forwarding,
// load-use stall detection, the ID/EX pipeline register and perf counters.
module id_operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic              clk,
  input logic              rst,
  id_operand_stage_if.slave bus
);

  logic [REG_ADDR_W-1:0] rs, rt, dec_dest, idex_dest;
  ctrl_t                 dec_ctrl, idex_ctrl;
  logic [DATA_W-1:0]     dec_imm, opa, opb;
  logic [DATA_W-1:0]     idex_pc, idex_opa, idex_opb, idex_imm;
  logic                  dec_uses_rt, idex_valid, ex_fwd_ok, hazard;
  logic [CNT_W-1:0]      stall_count, flush_count;

  assign rs          = bus.ifidInstr[25:21];
  assign rt          = bus.ifidInstr[20:16];
  assign bus.R1point = rs;
  assign bus.R2point = rt;

  id_decoder #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_decoder (
    .instr   (bus.ifidInstr),
    .ctrl    (dec_ctrl),
    .dest    (dec_dest),
    .imm     (dec_imm),
    .uses_rt (dec_uses_rt)
  );

  // A load in EX has no data yet, so it can never be an EX forwarding source
  assign ex_fwd_ok = idex_valid && idex_ctrl.regWrite && !idex_ctrl.memRead;

  assign hazard = bus.ifidValid && idex_valid && idex_ctrl.memRead &&
                  (idex_dest != '0) &&
                  ((idex_dest == rs) || ((idex_dest == rt) && dec_uses_rt));

  assign bus.stallIF = hazard && !bus.flush;

  // rs operand: r0 reads as zero since the register file lets r0 be written
  always_comb begin
    if (rs == '0)                                  opa = '0;
    else if (ex_fwd_ok && idex_dest == rs)         opa = bus.exFwdData;
    else if (bus.memRegWrite && bus.memDest == rs) opa = bus.memFwdData;
    else if (bus.wbRegWrite && bus.wbDest == rs)   opa = bus.wbFwdData;
    else                                           opa = bus.R1;
  end

  // rt operand: same priority chain as rs
  always_comb begin
    if (rt == '0)                                  opb = '0;
    else if (ex_fwd_ok && idex_dest == rt)         opb = bus.exFwdData;
    else if (bus.memRegWrite && bus.memDest == rt) opb = bus.memFwdData;
    else if (bus.wbRegWrite && bus.wbDest == rt)   opb = bus.wbFwdData;
    else                                           opb = bus.R2;
  end

  // ID/EX register: flush or load-use hazard inserts a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.flush || hazard) begin
      idex_valid <= 1'b0;
      idex_pc    <= '0;
      idex_opa   <= '0;
      idex_opb   <= '0;
      idex_imm   <= '0;
      idex_dest  <= '0;
      idex_ctrl  <= '0;
    end else begin
      idex_valid <= bus.ifidValid;
      idex_pc    <= bus.ifidPC;
      idex_opa   <= opa;
      idex_opb   <= opb;
      idex_imm   <= dec_imm;
      idex_dest  <= dec_dest;
      idex_ctrl  <= dec_ctrl;
    end
  end

  // Saturating counters; a flush takes precedence over a coincident stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (bus.flush) begin
      if (bus.ifidValid && flush_count != '1)
        flush_count <= flush_count + CNT_W'(1);
    end else if (hazard) begin
      if (stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign bus.idexValid     = idex_valid;
  assign bus.idexPC        = idex_pc;
  assign bus.idexOpA       = idex_opa;
  assign bus.idexOpB       = idex_opb;
  assign bus.idexImm       = idex_imm;
  assign bus.idexDest      = idex_dest;
  assign bus.idexRegWrite  = idex_ctrl.regWrite;
  assign bus.idexMemRead   = idex_ctrl.memRead;
  assign bus.idexMemWrite  = idex_ctrl.memWrite;
  assign bus.idexAluSrcImm = idex_ctrl.aluSrcImm;
  assign bus.idexAluOp     = idex_ctrl.aluOp;
  assign bus.idexBranch    = idex_ctrl.branch;
  assign bus.stallCount    = stall_count;
  assign bus.flushCount    = flush_count;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios followed by
// random traffic, all compared against a mnemonic-level pipeline model.
module tb_id_operand_stage;

  // Narrow counters so saturation is reachable in a short run
  localparam int TB_CNT_W = 6;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  id_operand_stage_if #(.CNT_W(TB_CNT_W)) bus ();

  id_operand_stage #(.CNT_W(TB_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit writes, rdmem, wrmem, immsrc, br, uses_rt;
    int alu;
    int dest;
  } ref_t;

  typedef struct {
    bit          valid;
    logic [31:0] pc, opa, opb, imm;
    int          dest;
    bit          rw, mr, mw, ais, br;
    int          alu;
  } exp_t;

  exp_t m;
  int   expStall;
  int   expFlush;

  function automatic logic [31:0] encR(input int fn, input int rd, input int rs, input int rt);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] encI(input int op, input int rt, input int rs, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  function automatic ref_t refDecode(input logic [31:0] ins);
    ref_t  r;
    string mn;
    r.writes = 0; r.rdmem = 0; r.wrmem = 0; r.immsrc = 0; r.br = 0;
    r.alu = 0; r.dest = 0;
    case (int'(ins[31:26]))
      0: case (int'(ins[5:0]))
           'h20: mn = "add";
           'h22: mn = "sub";
           'h24: mn = "and";
           'h25: mn = "or";
           'h2a: mn = "slt";
           default: mn = "nop";
         endcase
      8:  mn = "addi";
      35: mn = "lw";
      43: mn = "sw";
      4:  mn = "beq";
      default: mn = "nop";
    endcase
    r.uses_rt = (ins[31:26] == 6'd0) || (mn == "sw") || (mn == "beq");
    case (mn)
      "add":  begin r.writes = 1; r.alu = 0; r.dest = int'(ins[15:11]); end
      "sub":  begin r.writes = 1; r.alu = 1; r.dest = int'(ins[15:11]); end
      "and":  begin r.writes = 1; r.alu = 2; r.dest = int'(ins[15:11]); end
      "or":   begin r.writes = 1; r.alu = 3; r.dest = int'(ins[15:11]); end
      "slt":  begin r.writes = 1; r.alu = 4; r.dest = int'(ins[15:11]); end
      "addi": begin r.writes = 1; r.immsrc = 1; r.dest = int'(ins[20:16]); end
      "lw":   begin r.writes = 1; r.rdmem = 1; r.immsrc = 1; r.dest = int'(ins[20:16]); end
      "sw":   begin r.wrmem = 1; r.immsrc = 1; end
      "beq":  begin r.br = 1; r.alu = 1; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] refOperand(input int src, input logic [31:0] rf);
    if (src == 0) return 32'd0;
    if (m.valid && m.rw && !m.mr && m.dest == src) return bus.exFwdData;
    if (bus.memRegWrite && int'(bus.memDest) == src) return bus.memFwdData;
    if (bus.wbRegWrite && int'(bus.wbDest) == src) return bus.wbFwdData;
    return rf;
  endfunction

  function automatic exp_t bubble();
    exp_t b;
    b.valid = 0; b.pc = 0; b.opa = 0; b.opb = 0; b.imm = 0; b.dest = 0;
    b.rw = 0; b.mr = 0; b.mw = 0; b.ais = 0; b.br = 0; b.alu = 0;
    return b;
  endfunction

  task automatic checkField(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    checkField("idexValid", 32'(bus.idexValid), 32'(m.valid));
    checkField("idexPC", bus.idexPC, m.pc);
    checkField("idexOpA", bus.idexOpA, m.opa);
    checkField("idexOpB", bus.idexOpB, m.opb);
    checkField("idexImm", bus.idexImm, m.imm);
    checkField("idexDest", 32'(bus.idexDest), 32'(m.dest));
    checkField("idexRegWrite", 32'(bus.idexRegWrite), 32'(m.rw));
    checkField("idexMemRead", 32'(bus.idexMemRead), 32'(m.mr));
    checkField("idexMemWrite", 32'(bus.idexMemWrite), 32'(m.mw));
    checkField("idexAluSrcImm", 32'(bus.idexAluSrcImm), 32'(m.ais));
    checkField("idexAluOp", 32'(bus.idexAluOp), 32'(m.alu));
    checkField("idexBranch", 32'(bus.idexBranch), 32'(m.br));
    checkField("stallCount", 32'(bus.stallCount), 32'(expStall));
    checkField("flushCount", 32'(bus.flushCount), 32'(expFlush));
  endtask

  // Inputs are already driven; check combinational outputs, clock once, check ID/EX
  task automatic applyStimulus();
    ref_t        d;
    exp_t        nxt;
    int          rs, rt;
    bit          hz;
    logic [31:0] ins;
    #1;
    ins = bus.ifidInstr;
    rs  = int'(ins[25:21]);
    rt  = int'(ins[20:16]);
    d   = refDecode(ins);
    hz  = bus.ifidValid && m.valid && m.mr && m.dest != 0 &&
          (m.dest == rs || (m.dest == rt && d.uses_rt));
    checkField("R1point", 32'(bus.R1point), 32'(rs));
    checkField("R2point", 32'(bus.R2point), 32'(rt));
    checkField("stallIF", 32'(bus.stallIF), 32'(hz && !bus.flush));
    if (bus.flush) begin
      nxt = bubble();
      if (bus.ifidValid && expFlush < CNT_MAX) expFlush++;
    end else if (hz) begin
      nxt = bubble();
      if (expStall < CNT_MAX) expStall++;
    end else begin
      nxt.valid = bus.ifidValid;
      nxt.pc    = bus.ifidPC;
      nxt.opa   = refOperand(rs, bus.R1);
      nxt.opb   = refOperand(rt, bus.R2);
      nxt.imm   = 32'($signed(ins[15:0]));
      nxt.dest  = d.dest;
      nxt.rw    = d.writes;
      nxt.mr    = d.rdmem;
      nxt.mw    = d.wrmem;
      nxt.ais   = d.immsrc;
      nxt.br    = d.br;
      nxt.alu   = d.alu;
    end
    @(posedge clk);
    #1;
    m = nxt;
    checkOutput();
  endtask

  task automatic setIdle();
    bus.ifidInstr   = 32'd0;
    bus.ifidValid   = 1'b0;
    bus.ifidPC      = 32'd0;
    bus.flush       = 1'b0;
    bus.R1          = 32'd0;
    bus.R2          = 32'd0;
    bus.exFwdData   = 32'd0;
    bus.memRegWrite = 1'b0;
    bus.memDest     = 5'd0;
    bus.memFwdData  = 32'd0;
    bus.wbRegWrite  = 1'b0;
    bus.wbDest      = 5'd0;
    bus.wbFwdData   = 32'd0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    bus.ifidInstr = ins;
    bus.ifidValid = 1'b1;
    bus.ifidPC    = pc;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m           = bubble();
    expStall    = 0;
    expFlush    = 0;
    rst         = 1'b1;
    setIdle();

    // Reset state
    #2;
    checkOutput();
    checkField("reset_stallIF", 32'(bus.stallIF), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Independent add r3,r1,r2
    $display("[TB] independent op");
    issue(encR('h20, 3, 1, 2), 32'h100);
    bus.R1 = 32'd5;
    bus.R2 = 32'd3;
    applyStimulus();
    checkField("t1_opa", bus.idexOpA, 32'd5);
    checkField("t1_opb", bus.idexOpB, 32'd3);
    checkField("t1_dest", 32'(bus.idexDest), 32'd3);

    // EX forwarding: addi r1,r0,7 then add r2,r1,r1
    $display("[TB] EX forwarding");
    issue(encI(8, 1, 0, 16'd7), 32'h104);
    applyStimulus();
    issue(encR('h20, 2, 1, 1), 32'h108);
    bus.R1 = 32'd99;
    bus.R2 = 32'd99;
    bus.exFwdData = 32'd7;
    applyStimulus();
    checkField("ex_fwd_opa", bus.idexOpA, 32'd7);
    checkField("ex_fwd_opb", bus.idexOpB, 32'd7);
    issue(encI(8, 1, 0, 16'd7), 32'h10C);
    applyStimulus();
    issue(encR('h20, 2, 1, 1), 32'h110);
    bus.memRegWrite = 1'b1; bus.memDest = 5'd1; bus.memFwdData = 32'h111;
    bus.wbRegWrite  = 1'b1; bus.wbDest  = 5'd1; bus.wbFwdData  = 32'h222;
    applyStimulus();
    checkField("ex_prio_opa", bus.idexOpA, 32'd7);
    setIdle();

    // Load-use: lw r4,0(r0) then add r5,r4,r4
    $display("[TB] load-use");
    issue(encI(35, 4, 0, 16'd0), 32'h200);
    applyStimulus();
    issue(encR('h20, 5, 4, 4), 32'h204);
    #1;
    checkField("lu_stall_on", 32'(bus.stallIF), 32'd1);
    applyStimulus();
    checkField("lu_bubble", 32'(bus.idexValid), 32'd0);
    bus.memRegWrite = 1'b1; bus.memDest = 5'd4; bus.memFwdData = 32'hDEADBEEF;
    #1;
    checkField("lu_stall_off", 32'(bus.stallIF), 32'd0);
    applyStimulus();
    checkField("lu_opa", bus.idexOpA, 32'hDEADBEEF);
    checkField("lu_stallCount", 32'(bus.stallCount), 32'd1);
    setIdle();

    // sw r4 and addi r6,r4 as consumers also stall
    issue(encI(35, 4, 0, 16'd0), 32'h208);
    applyStimulus();
    issue(encI(43, 4, 0, 16'd8), 32'h20C);
    #1;
    checkField("sw_stall", 32'(bus.stallIF), 32'd1);
    applyStimulus();
    applyStimulus();
    issue(encI(35, 4, 0, 16'd0), 32'h210);
    applyStimulus();
    issue(encI(8, 6, 4, 16'hFFF0), 32'h214);
    #1;
    checkField("addi_stall", 32'(bus.stallIF), 32'd1);
    applyStimulus();
    applyStimulus();

    // r0 is always zero; WB bypass beats stale register file
    $display("[TB] r0 and WB bypass");
    bus.wbRegWrite = 1'b1; bus.wbDest = 5'd0; bus.wbFwdData = 32'd9;
    bus.R1 = 32'd9; bus.R2 = 32'd9;
    issue(encR('h20, 3, 0, 0), 32'h300);
    applyStimulus();
    checkField("r0_opa", bus.idexOpA, 32'd0);
    bus.wbDest = 5'd8; bus.wbFwdData = 32'h55; bus.R1 = 32'd0;
    issue(encR('h20, 3, 8, 0), 32'h304);
    applyStimulus();
    checkField("wb_bypass", bus.idexOpA, 32'h55);
    setIdle();

    // Flush beats a coincident load-use hazard
    $display("[TB] flush precedence");
    issue(encI(35, 4, 0, 16'd0), 32'h400);
    applyStimulus();
    issue(encR('h20, 5, 4, 4), 32'h404);
    bus.flush = 1'b1;
    #1;
    checkField("flush_stallIF", 32'(bus.stallIF), 32'd0);
    applyStimulus();
    checkField("flush_bubble", 32'(bus.idexValid), 32'd0);
    checkField("flush_count", 32'(bus.flushCount), 32'd1);
    setIdle();

    // Asynchronous reset in the middle of a stall
    $display("[TB] reset mid-stall");
    issue(encI(35, 4, 0, 16'd0), 32'h500);
    applyStimulus();
    issue(encR('h20, 5, 4, 4), 32'h504);
    #1;
    checkField("rst_pre_stall", 32'(bus.stallIF), 32'd1);
    rst = 1'b1;
    #1;
    m = bubble();
    expStall = 0;
    expFlush = 0;
    checkOutput();
    checkField("rst_stallIF", 32'(bus.stallIF), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    setIdle();

    // Counter saturation: lw r4,0(r4) repeated stalls every other cycle
    $display("[TB] stall counter saturation");
    issue(encI(35, 4, 4, 16'd0), 32'h600);
    for (int i = 0; i < 2 * (CNT_MAX + 4) + 1; i++) applyStimulus();
    checkField("stall_sat", 32'(bus.stallCount), 32'(CNT_MAX));
    setIdle();

    // Random traffic against the model
    $display("[TB] random phase");
    for (int i = 0; i < 400; i++) begin
      int sel;
      int rd, rsr, rtr;
      logic [15:0] imm;
      sel = int'($urandom_range(0, 9));
      rd  = int'($urandom_range(0, 7));
      rsr = int'($urandom_range(0, 7));
      rtr = int'($urandom_range(0, 7));
      imm = 16'($urandom);
      case (sel)
        0: bus.ifidInstr = encR('h20, rd, rsr, rtr);
        1: bus.ifidInstr = encR('h22, rd, rsr, rtr);
        2: bus.ifidInstr = encR((($urandom & 1) != 0) ? 'h24 : 'h25, rd, rsr, rtr);
        3: bus.ifidInstr = encR((($urandom & 1) != 0) ? 'h2a : 'h3f, rd, rsr, rtr);
        4: bus.ifidInstr = encI(8, rtr, rsr, imm);
        5, 6: bus.ifidInstr = encI(35, rtr, rsr, imm);
        7: bus.ifidInstr = encI(43, rtr, rsr, imm);
        8: bus.ifidInstr = encI(4, rtr, rsr, imm);
        default: bus.ifidInstr = encI(int'($urandom_range(9, 63)), rtr, rsr, imm);
      endcase
      bus.ifidValid   = ($urandom_range(0, 7) != 0);
      bus.ifidPC      = $urandom;
      bus.flush       = ($urandom_range(0, 7) == 0);
      bus.R1          = $urandom;
      bus.R2          = $urandom;
      bus.exFwdData   = $urandom;
      bus.memRegWrite = 1'($urandom);
      bus.memDest     = 5'($urandom_range(0, 7));
      bus.memFwdData  = $urandom;
      bus.wbRegWrite  = 1'($urandom);
      bus.wbDest      = 5'($urandom_range(0, 7));
      bus.wbFwdData   = $urandom;
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
